// File: rtl/tank_level_controller.sv
// -----------------------------------------------------------------------------
// tank_level_controller
//
// Purpose:
//   Upstream stage of the irrigation controller. Samples the two raw float
//   switches (low mark, high mark), synchronises and debounces each of them,
//   and runs a fill-valve hysteresis FSM. The valve opens when the water drops
//   below the low mark and closes once the high mark is reached. An implausible
//   switch combination (high wet, low dry) or a fill that takes too long puts
//   the block into a latched FAULT state with the valve shut.
//
// Ports:
//   clock           in   1  system clock, rising edge
//   reset           in   1  asynchronous, active-high; returns the block to IDLE
//   level_low_raw   in   1  raw low-mark switch (async), 1 = water at/above low mark
//   level_high_raw  in   1  raw high-mark switch (async), 1 = water at/above high mark
//   fault_clear     in   1  synchronous level; leaves FAULT
//   fill_valve      out  1  1 = inlet valve open (FILLING)
//   full_tank       out  1  1 = tank at high mark (FULL)
//   water_ok        out  1  1 = water usable, valve closed (FULL or SERVING)
//   fault           out  1  1 = in FAULT
//   state_dbg       out  3  current state encoding
// -----------------------------------------------------------------------------
module tank_level_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FILL_TIMEOUT    = 1024,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       level_low_raw,
  input  logic       level_high_raw,
  input  logic       fault_clear,
  output logic       fill_valve,
  output logic       full_tank,
  output logic       water_ok,
  output logic       fault,
  output logic [2:0] state_dbg
);

  // State encodings are visible on state_dbg, so they are fixed values.
  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_FILLING = 3'b001;
  localparam logic [2:0] ST_FULL    = 3'b010;
  localparam logic [2:0] ST_SERVING = 3'b011;
  localparam logic [2:0] ST_FAULT   = 3'b100;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Channel 0 = low-mark switch, channel 1 = high-mark switch.
  logic [1:0] w_raw;
  logic [1:0] w_db;

  assign w_raw = {level_high_raw, level_low_raw};

  // ---------------------------------------------------------------------------
  // Per-switch synchroniser and debouncer.
  // The debounced level only moves after the synchronised sample has disagreed
  // with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample restarts
  // the count, so shorter glitches are swallowed entirely.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic             r_meta;
      logic             r_sync;
      logic             r_db;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_meta <= 1'b0;
          r_sync <= 1'b0;
          r_db   <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_meta <= w_raw[gi];
          r_sync <= r_meta;
          if (r_sync == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt >= DB_LAST) begin
            r_db  <= r_sync;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_db[gi] = r_db;
    end
  endgenerate

  logic w_db_low;
  logic w_db_high;
  logic w_inconsistent;

  assign w_db_low  = w_db[0];
  assign w_db_high = w_db[1];
  // A wet high switch above a dry low switch cannot be a real water level.
  assign w_inconsistent = w_db_high & ~w_db_low;

  // ---------------------------------------------------------------------------
  // Fill-valve FSM
  // ---------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [CNT_W-1:0] r_fill_timer;
  logic             w_fill_expired;

  // Timer value equals the number of completed cycles in FILLING, so the
  // comparison against FILL_TIMEOUT-1 fires in the FILLING_TIMEOUT-th cycle.
  assign w_fill_expired = (r_fill_timer == FILL_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_inconsistent)  w_state_next = ST_FAULT;
        else if (w_db_high)  w_state_next = ST_FULL;
        else                 w_state_next = ST_FILLING;
      end
      ST_FILLING: begin
        // Reaching the high mark wins over a timeout in the same cycle.
        if (w_inconsistent)      w_state_next = ST_FAULT;
        else if (w_db_high)      w_state_next = ST_FULL;
        else if (w_fill_expired) w_state_next = ST_FAULT;
        else                     w_state_next = ST_FILLING;
      end
      ST_FULL: begin
        if (w_inconsistent)  w_state_next = ST_FAULT;
        else if (!w_db_high) w_state_next = ST_SERVING;
        else                 w_state_next = ST_FULL;
      end
      ST_SERVING: begin
        if (w_inconsistent)  w_state_next = ST_FAULT;
        else if (w_db_high)  w_state_next = ST_FULL;
        else if (!w_db_low)  w_state_next = ST_FILLING;
        else                 w_state_next = ST_SERVING;
      end
      ST_FAULT: begin
        // Sticky; leaving goes through IDLE, which re-evaluates the sensors.
        if (fault_clear) w_state_next = ST_IDLE;
        else             w_state_next = ST_FAULT;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Held at zero outside FILLING, which also gives the clear-on-entry
  // behaviour; counts up while filling and sticks at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fill_timer <= '0;
    end else if (r_state != ST_FILLING) begin
      r_fill_timer <= '0;
    end else if (r_fill_timer != CNT_MAX) begin
      r_fill_timer <= r_fill_timer + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs, decoded from the state register only. Because the state
  // register resets asynchronously, the valve closes as soon as reset rises.
  // ---------------------------------------------------------------------------
  assign fill_valve = (r_state == ST_FILLING);
  assign full_tank  = (r_state == ST_FULL);
  assign water_ok   = (r_state == ST_FULL) | (r_state == ST_SERVING);
  assign fault      = (r_state == ST_FAULT);
  assign state_dbg  = r_state;

endmodule
